// File: rtl/fifo_uart_tx_drainer.sv
// fifo_uart_tx_drainer
//   Drains the TX FIFO read port one byte at a time and serialises each byte
//   onto the UART txd line: start bit, 8 data bits LSB first, then 1 or 2 stop bits.
//   This block is the only reader of the FIFO. It pops exactly once per frame.
//
// Ports
//   clk               system clock, all state changes on posedge
//   reset_n           asynchronous active-low reset
//   enable            1 = may start new frames; 0 = finish current frame, then idle
//   fifo_read_ready   FIFO non-empty
//   fifo_read_data    FIFO head byte (registered RAM output, lags head pointer by 1 cycle)
//   fifo_read_enable  single-cycle pop strobe
//   txd               UART serial output, idle high
//   busy              high from WAIT through the last stop-bit cycle
//   byte_sent         1-cycle pulse on the final stop-bit cycle of each frame
//
// state | meaning
// IDLE  | txd high, waiting for enable and a non-empty FIFO
// WAIT  | one cycle for the registered RAM output to settle
// LOAD  | capture head byte into shift_reg, pop strobe high
// START | start bit (txd low) for CLKS_PER_BIT cycles
// DATA  | 8 data bits LSB first, CLKS_PER_BIT cycles each
// STOP  | txd high for STOP_BITS*CLKS_PER_BIT cycles, byte_sent on the last one

module fifo_uart_tx_drainer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       fifo_read_ready,
  input  logic [7:0] fifo_read_data,
  output logic       fifo_read_enable,
  output logic       txd,
  output logic       busy,
  output logic       byte_sent
);

  localparam int            CW         = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_PENULT = CW'(CLKS_PER_BIT - 2);
  localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic          stop_idx;
  logic [7:0]    shift_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      txd              <= 1'b1;
      fifo_read_enable <= 1'b0;
      busy             <= 1'b0;
      byte_sent        <= 1'b0;
      baud_cnt         <= '0;
      bit_idx          <= '0;
      stop_idx         <= 1'b0;
      shift_reg        <= '0;
    end else begin
      fifo_read_enable <= 1'b0;
      byte_sent        <= 1'b0;
      case (state)
        IDLE: begin
          txd <= 1'b1;
          // Emptiness is only checked here; nobody else pops, so the FIFO
          // cannot drain before the pop in LOAD.
          if (enable && fifo_read_ready) begin
            state <= WAIT;
            busy  <= 1'b1;
          end
        end
        WAIT: begin
          state            <= LOAD;
          fifo_read_enable <= 1'b1;
        end
        LOAD: begin
          // Head byte is still on the RAM output at the pop edge; the pointer
          // advance only shows up on fifo_read_data a cycle later.
          shift_reg <= fifo_read_data;
          baud_cnt  <= '0;
          txd       <= 1'b0;
          state     <= START;
        end
        START: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            txd       <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
            state     <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              txd      <= 1'b1;
              stop_idx <= 1'b0;
              state    <= STOP;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              txd       <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            if (stop_idx == STOP_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
            // Registered pulse: raise it on the edge that enters the final cycle.
            if (baud_cnt == BIT_PENULT && stop_idx == STOP_LAST)
              byte_sent <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx_drainer.sv
module tb_fifo_uart_tx_drainer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       enable2 = 1'b0;
  logic       fifo_read_ready = 1'b0;
  logic       fifo_read_ready2 = 1'b0;
  logic [7:0] fifo_read_data = 8'h00;
  logic [7:0] fifo_read_data2 = 8'h00;
  logic       fifo_read_enable, txd, busy, byte_sent;
  logic       fifo_read_enable2, txd2, busy2, byte_sent2;

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic [7:0] q2[$];
  logic [7:0] head_prev = 8'h00;
  logic [7:0] head_prev2 = 8'h00;
  logic       pop_s, pop_s2;
  int pops = 0, pops2 = 0, bad_pops = 0;

  always #5 clk = ~clk;

  fifo_uart_tx_drainer #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .fifo_read_ready(fifo_read_ready), .fifo_read_data(fifo_read_data),
    .fifo_read_enable(fifo_read_enable), .txd(txd), .busy(busy), .byte_sent(byte_sent)
  );

  fifo_uart_tx_drainer #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable(enable2),
    .fifo_read_ready(fifo_read_ready2), .fifo_read_data(fifo_read_data2),
    .fifo_read_enable(fifo_read_enable2), .txd(txd2), .busy(busy2), .byte_sent(byte_sent2)
  );

  // FIFO models: pop on the edge where the strobe was high; read data is a
  // registered copy of the head, one cycle behind the head pointer.
  always begin
    @(posedge clk);
    pop_s  = fifo_read_enable;
    pop_s2 = fifo_read_enable2;
    #1;
    fifo_read_data  = head_prev;
    fifo_read_data2 = head_prev2;
    if (pop_s) begin
      if (q.size() != 0) begin void'(q.pop_front()); pops++; end
      else bad_pops++;
    end
    if (pop_s2) begin
      if (q2.size() != 0) begin void'(q2.pop_front()); pops2++; end
      else bad_pops++;
    end
    head_prev        = (q.size() != 0) ? q[0] : 8'h00;
    head_prev2       = (q2.size() != 0) ? q2[0] : 8'h00;
    fifo_read_ready  = (q.size() != 0);
    fifo_read_ready2 = (q2.size() != 0);
  end

  function automatic logic [63:0] exp_wave(input logic [7:0] b, input int stop_bits);
    logic [63:0] w;
    logic [10:0] frame;
    w = '1;
    frame = {2'b11, b, 1'b0};
    for (int i = 0; i < (9 + stop_bits) * 4; i++) w[i] = frame[i / 4];
    return w;
  endfunction

  // Waits for a start bit, then records txd per cycle over one frame.
  task automatic capture(input bit sel, input int stop_bits, input int drop_at,
                         output logic [63:0] wave, output int gap, output int sent_cnt,
                         output int sent_at, output int busy_low, output bit timeout);
    int n;
    n = (9 + stop_bits) * 4;
    wave = '1; gap = 0; sent_cnt = 0; sent_at = 0; busy_low = 0; timeout = 1'b0;
    @(negedge clk);
    while ((sel ? txd2 : txd) === 1'b1 && gap < 200) begin
      gap++;
      @(negedge clk);
    end
    if ((sel ? txd2 : txd) !== 1'b0) begin
      timeout = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (drop_at > 0 && i == drop_at) enable = 1'b0;
      wave[i] = sel ? txd2 : txd;
      if ((sel ? byte_sent2 : byte_sent) === 1'b1) begin sent_cnt++; sent_at = i + 1; end
      if ((sel ? busy2 : busy) !== 1'b1) busy_low++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; enable = 1'b0; enable2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd got=%b exp=1", txd); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fifo_read_enable !== 1'b0) begin failures++; $display("FAIL reset_pop got=%b exp=0", fifo_read_enable); end
    checks++; if (byte_sent !== 1'b0) begin failures++; $display("FAIL reset_byte_sent got=%b exp=0", byte_sent); end
    checks++; if (txd2 !== 1'b1) begin failures++; $display("FAIL reset_txd2 got=%b exp=1", txd2); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single_byte;
    logic [63:0] w; int g, sc, sa, bl, p0; bit to;
    p0 = pops;
    enable = 1'b1;
    q.push_back(8'hA5);
    capture(1'b0, 1, 0, w, g, sc, sa, bl, to);
    checks++; if (to) begin failures++; $display("FAIL single_timeout got=timeout exp=start_bit"); end
    checks++; if (w !== exp_wave(8'hA5, 1)) begin failures++; $display("FAIL single_wave got=%h exp=%h", w, exp_wave(8'hA5, 1)); end
    checks++; if (g !== 3) begin failures++; $display("FAIL single_start_latency got=%0d exp=3", g); end
    checks++; if (sc !== 1) begin failures++; $display("FAIL single_sent_count got=%0d exp=1", sc); end
    checks++; if (sa !== 40) begin failures++; $display("FAIL single_sent_cycle got=%0d exp=40", sa); end
    checks++; if (bl !== 0) begin failures++; $display("FAIL single_busy_low got=%0d exp=0", bl); end
    checks++; if (pops - p0 !== 1) begin failures++; $display("FAIL single_pops got=%0d exp=1", pops - p0); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || txd !== 1'b1) begin failures++; $display("FAIL single_idle got=busy%b_txd%b exp=busy0_txd1", busy, txd); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3];
    logic [63:0] w; int g, sc, sa, bl, p0; bit to;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
    p0 = pops;
    enable = 1'b1;
    for (int k = 0; k < 3; k++) q.push_back(bytes[k]);
    for (int k = 0; k < 3; k++) begin
      capture(1'b0, 1, 0, w, g, sc, sa, bl, to);
      checks++; if (to) begin failures++; $display("FAIL b2b_timeout frame=%0d got=timeout exp=start_bit", k); end
      checks++; if (w !== exp_wave(bytes[k], 1)) begin failures++; $display("FAIL b2b_wave frame=%0d got=%h exp=%h", k, w, exp_wave(bytes[k], 1)); end
      checks++; if (g !== 3) begin failures++; $display("FAIL b2b_gap frame=%0d got=%0d exp=3", k, g); end
      checks++; if (sc !== 1 || sa !== 40) begin failures++; $display("FAIL b2b_sent frame=%0d got=%0d@%0d exp=1@40", k, sc, sa); end
    end
    checks++; if (pops - p0 !== 3) begin failures++; $display("FAIL b2b_pops got=%0d exp=3", pops - p0); end
  endtask

  task automatic test_enable_drop;
    logic [63:0] w; int g, sc, sa, bl, p0, viol; bit to;
    p0 = pops;
    enable = 1'b1;
    q.push_back(8'h55);
    q.push_back(8'h66);
    capture(1'b0, 1, 16, w, g, sc, sa, bl, to);
    checks++; if (w !== exp_wave(8'h55, 1)) begin failures++; $display("FAIL drop_wave got=%h exp=%h", w, exp_wave(8'h55, 1)); end
    checks++; if (sc !== 1) begin failures++; $display("FAIL drop_sent got=%0d exp=1", sc); end
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || fifo_read_enable !== 1'b0) viol++;
    end
    checks++; if (viol !== 0) begin failures++; $display("FAIL drop_parked got=%0d_bad_cycles exp=0", viol); end
    checks++; if (pops - p0 !== 1) begin failures++; $display("FAIL drop_pops got=%0d exp=1", pops - p0); end
    checks++; if (q.size() !== 1) begin failures++; $display("FAIL drop_queue got=%0d exp=1", q.size()); end
    enable = 1'b1;
    capture(1'b0, 1, 0, w, g, sc, sa, bl, to);
    checks++; if (to) begin failures++; $display("FAIL resume_timeout got=timeout exp=start_bit"); end
    checks++; if (w !== exp_wave(8'h66, 1)) begin failures++; $display("FAIL resume_wave got=%h exp=%h", w, exp_wave(8'h66, 1)); end
    checks++; if (pops - p0 !== 2) begin failures++; $display("FAIL resume_pops got=%0d exp=2", pops - p0); end
  endtask

  task automatic test_stop_bits2;
    logic [63:0] w; int g, sc, sa, bl, p0; bit to;
    p0 = pops2;
    enable2 = 1'b1;
    q2.push_back(8'h81);
    capture(1'b1, 2, 0, w, g, sc, sa, bl, to);
    checks++; if (to) begin failures++; $display("FAIL stop2_timeout got=timeout exp=start_bit"); end
    checks++; if (w !== exp_wave(8'h81, 2)) begin failures++; $display("FAIL stop2_wave got=%h exp=%h", w, exp_wave(8'h81, 2)); end
    checks++; if (sc !== 1 || sa !== 44) begin failures++; $display("FAIL stop2_sent got=%0d@%0d exp=1@44", sc, sa); end
    checks++; if (bl !== 0) begin failures++; $display("FAIL stop2_busy_low got=%0d exp=0", bl); end
    checks++; if (pops2 - p0 !== 1) begin failures++; $display("FAIL stop2_pops got=%0d exp=1", pops2 - p0); end
    @(negedge clk);
    checks++; if (busy2 !== 1'b0 || txd2 !== 1'b1) begin failures++; $display("FAIL stop2_idle got=busy%b_txd%b exp=busy0_txd1", busy2, txd2); end
  endtask

  task automatic test_empty_idle;
    int viol, p0;
    p0 = pops;
    enable = 1'b1;
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || fifo_read_enable !== 1'b0) viol++;
    end
    checks++; if (viol !== 0) begin failures++; $display("FAIL empty_idle got=%0d_bad_cycles exp=0", viol); end
    checks++; if (pops - p0 !== 0) begin failures++; $display("FAIL empty_pops got=%0d exp=0", pops - p0); end
  endtask

  task automatic test_reset_mid_frame;
    int n, viol, p0;
    p0 = pops;
    enable = 1'b1;
    q.push_back(8'h3C);
    n = 0;
    @(negedge clk);
    while (txd === 1'b1 && n < 50) begin n++; @(negedge clk); end
    checks++; if (txd !== 1'b0) begin failures++; $display("FAIL midrst_timeout got=txd%b exp=start_bit", txd); end
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b1 || txd !== 1'b0) begin failures++; $display("FAIL midrst_in_data got=busy%b_txd%b exp=busy1_txd0", busy, txd); end
    reset_n = 1'b0;
    #1;
    checks++; if (txd !== 1'b1 || busy !== 1'b0 || fifo_read_enable !== 1'b0) begin
      failures++; $display("FAIL midrst_async got=txd%b_busy%b_pop%b exp=txd1_busy0_pop0", txd, busy, fifo_read_enable);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    viol = 0;
    repeat (30) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) viol++;
    end
    checks++; if (viol !== 0) begin failures++; $display("FAIL midrst_idle got=%0d_bad_cycles exp=0", viol); end
    checks++; if (pops - p0 !== 1) begin failures++; $display("FAIL midrst_pops got=%0d exp=1", pops - p0); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_enable_drop();
    test_stop_bits2();
    test_empty_idle();
    test_reset_mid_frame();
    checks++; if (bad_pops !== 0) begin failures++; $display("FAIL pop_when_empty got=%0d exp=0", bad_pops); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
